// File: rtl/microseq_control.sv
// Microcoded control sequencer. Opcode + micro-PC index a bootstrapped microcode RAM. The
// registered microword is decoded into one-hot load enables and one-cold bus drive enables.
module microseq_control #(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned UPC_W    = 5,
   parameter int unsigned CTRL_W   = 6,
   parameter int unsigned RSEL_W   = 2,
   parameter int unsigned N_IN     = 8,
   parameter int unsigned N_OUT    = 8,
   parameter int unsigned MISC_W   = 4,
   parameter int unsigned N_FLAGS  = 4
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [OPCODE_W-1:0]         OPWORD_OPCODE,
   input  logic [N_FLAGS-1:0]          FLAGS,
   input  logic                        BUS_RDY,
   input  logic                        BOOTED,
   input  logic                        BOOT_WE,
   input  logic [OPCODE_W+UPC_W+1:0]   BOOT_ADDR,
   input  logic [7:0]                  BOOT_DATA,
   output logic [CTRL_W-1:0]           CTRL_DATA,
   output logic [RSEL_W-1:0]           REG_SEL,
   output logic [MISC_W-1:0]           MISC2_PLANE,
   output logic [N_IN-1:0]             IN_EN,
   output logic [N_OUT-1:0]            OUT_N,
   output logic                        UPC_OVF,
   output logic                        BOOT_ERR
);

   localparam int unsigned OSEL_W   = $clog2(N_OUT);
   localparam int unsigned ISEL_W   = $clog2(N_IN);
   localparam int unsigned CSEL_W   = $clog2(N_FLAGS);
   localparam int unsigned RSEL_LSB = CTRL_W;
   localparam int unsigned OSEL_LSB = RSEL_LSB + RSEL_W;
   localparam int unsigned ISEL_LSB = OSEL_LSB + OSEL_W;
   localparam int unsigned SEQ_LSB  = ISEL_LSB + ISEL_W;
   localparam int unsigned CSEL_LSB = SEQ_LSB + 2;
   localparam int unsigned MISC_LSB = CSEL_LSB + CSEL_W;
   localparam int unsigned MW_USED  = MISC_LSB + MISC_W;
   localparam int unsigned WADDR_W  = OPCODE_W + UPC_W;
   localparam int unsigned N_WORDS  = 2 ** WADDR_W;

   localparam logic [1:0] SEQ_NEXT = 2'b00;
   localparam logic [1:0] SEQ_END  = 2'b01;
   localparam logic [1:0] SEQ_SKIP = 2'b10;
   localparam logic [1:0] SEQ_WAIT = 2'b11;

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_PRIME = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   logic [31:0]         r_ram [N_WORDS];
   logic [MW_USED-1:0]  r_mw;
   logic [1:0]          r_state;
   logic [UPC_W-1:0]    r_upc;
   logic [OPCODE_W-1:0] r_opc;
   logic                r_ovf;
   logic                r_boot_err;

   logic [1:0]          w_state_n;
   logic [UPC_W-1:0]    w_upc_n;
   logic [OPCODE_W-1:0] w_opc_n;
   logic [WADDR_W-1:0]  w_addr_n;
   logic [1:0]          w_inc;
   logic [UPC_W:0]      w_sum;
   logic                w_ovf_set;

   logic [CTRL_W-1:0]   w_ctrl;
   logic [RSEL_W-1:0]   w_rsel;
   logic [OSEL_W-1:0]   w_out_sel;
   logic [ISEL_W-1:0]   w_in_sel;
   logic [1:0]          w_seq;
   logic [CSEL_W-1:0]   w_cond_sel;
   logic [MISC_W-1:0]   w_misc;
   logic                w_flag;
   logic                w_active;
   logic                w_fire;
   logic                w_load;

   assign w_ctrl     = r_mw[0 +: CTRL_W];
   assign w_rsel     = r_mw[RSEL_LSB +: RSEL_W];
   assign w_out_sel  = r_mw[OSEL_LSB +: OSEL_W];
   assign w_in_sel   = r_mw[ISEL_LSB +: ISEL_W];
   assign w_seq      = r_mw[SEQ_LSB +: 2];
   assign w_cond_sel = r_mw[CSEL_LSB +: CSEL_W];
   assign w_misc     = r_mw[MISC_LSB +: MISC_W];

   // Shifted one-hot masks give "none" for out-of-range select codes for free
   assign w_flag   = |(FLAGS & (N_FLAGS'(1) << w_cond_sel));
   assign w_active = (r_state == S_RUN) || (r_state == S_WAIT);
   assign w_fire   = w_active && BOOTED && ((w_seq != SEQ_WAIT) || BUS_RDY);
   assign w_load   = (w_in_sel == ISEL_W'(N_IN - 1));
   assign w_addr_n = {w_opc_n, w_upc_n};

   // Next state, micro-PC and opcode
   always_comb begin
      w_state_n = r_state;
      w_upc_n   = r_upc;
      w_opc_n   = r_opc;
      w_ovf_set = 1'b0;
      w_inc     = 2'd0;
      w_sum     = '0;
      case (r_state)
         S_BOOT: begin
            w_upc_n = '0;
            if (BOOTED) w_state_n = S_PRIME;
         end
         S_PRIME: begin
            w_upc_n   = '0;
            w_state_n = S_RUN;
         end
         default: begin
            w_state_n = (w_seq == SEQ_WAIT && !BUS_RDY) ? S_WAIT : S_RUN;
            if (w_fire) begin
               case (w_seq)
                  SEQ_NEXT: w_inc = 2'd1;
                  SEQ_SKIP: w_inc = w_flag ? 2'd2 : 2'd1;
                  SEQ_WAIT: w_inc = 2'd1;
                  default:  w_inc = 2'd0;
               endcase
               w_sum = {1'b0, r_upc} + (UPC_W+1)'(w_inc);
               if (w_seq == SEQ_END) begin
                  w_upc_n = '0;
               end else begin
                  w_upc_n   = w_sum[UPC_W-1:0];
                  w_ovf_set = w_sum[UPC_W];
               end
               if (w_load) w_opc_n = w_misc[0] ? OPCODE_W'(w_ctrl) : OPWORD_OPCODE;
            end
         end
      endcase
      if (!BOOTED) begin
         w_state_n = S_BOOT;
         w_upc_n   = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_BOOT;
         r_upc      <= '0;
         r_opc      <= '0;
         r_mw       <= '0;
         r_ovf      <= 1'b0;
         r_boot_err <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_upc      <= w_upc_n;
         r_opc      <= w_opc_n;
         r_mw       <= r_ram[w_addr_n][MW_USED-1:0];
         r_ovf      <= r_ovf | w_ovf_set;
         r_boot_err <= r_boot_err | (BOOT_WE & BOOTED);
      end
   end

   // Microcode store: byte-lane writes only while bootstrapping, contents survive reset
   always_ff @(posedge CLK) begin
      if (!RST && BOOT_WE && !BOOTED)
         r_ram[BOOT_ADDR[WADDR_W+1:2]][{BOOT_ADDR[1:0], 3'b000} +: 8] <= BOOT_DATA;
   end

   // Plane decode; idle in BOOT/PRIME, load enables suppressed while waiting on the bus
   always_comb begin
      IN_EN       = '0;
      OUT_N       = '1;
      CTRL_DATA   = '0;
      REG_SEL     = '0;
      MISC2_PLANE = '0;
      if (w_active) begin
         CTRL_DATA   = w_ctrl;
         REG_SEL     = w_rsel;
         MISC2_PLANE = w_misc;
         if (w_out_sel != '0) OUT_N = ~(N_OUT'(1) << w_out_sel);
      end
      if (w_fire && (w_in_sel != '0)) IN_EN = N_IN'(1) << w_in_sel;
   end

   assign UPC_OVF  = r_ovf;
   assign BOOT_ERR = r_boot_err;

endmodule
